// File: rtl/reset_seq_pkg.sv
// Shared definitions for the staged reset sequencer: reset-cause codes,
// sequencer state encoding, sizing limits and the terminal-count helper.
package reset_seq_pkg;

    // Cause codes reported on reset_cause_o; 00 and 11 are never produced.
    localparam logic [1:0] RST_CAUSE_HARD = 2'b01;
    localparam logic [1:0] RST_CAUSE_SOFT = 2'b10;

    // Largest number of reset domains supported, and the index width that
    // covers all of them (kept fixed so a 1-stage build still has a legal index).
    localparam int MAX_STAGES = 16;
    localparam int IDX_W      = 4;

    // Widest cycle counter the terminal-count helper can compare.
    localparam int MAX_CNT_W  = 32;

    // HOLD keeps every domain in reset, RELEASE frees domains one by one,
    // DONE idles with all domains running until a warm reset is accepted.
    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } seq_state_t;

    // Exact terminal-count match; callers zero-extend to MAX_CNT_W so the
    // same helper serves any counter width up to the maximum.
    function automatic logic is_terminal(input logic [MAX_CNT_W-1:0] count,
                                         input logic [MAX_CNT_W-1:0] term);
        return (count == term);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Bundle of the sequencer's SoC-facing signals: the warm-reset handshake,
// the per-domain reset outputs, the completion flag and the reset cause.
// The master side is the sequencer; the slave side is the SoC / requester.
interface reset_sequencer_if #(
    parameter int NUM_STAGES = 4
);

    logic                  soft_rst_req_i;
    logic                  soft_rst_ack_o;
    logic [NUM_STAGES-1:0] stage_rst_o;
    logic [NUM_STAGES-1:0] stage_nrst_o;
    logic                  seq_done_o;
    logic [1:0]            reset_cause_o;

    modport master (
        input  soft_rst_req_i,
        output soft_rst_ack_o,
        output stage_rst_o,
        output stage_nrst_o,
        output seq_done_o,
        output reset_cause_o
    );

    modport slave (
        output soft_rst_req_i,
        input  soft_rst_ack_o,
        input  stage_rst_o,
        input  stage_nrst_o,
        input  seq_done_o,
        input  reset_cause_o
    );

endinterface

// File: rtl/reset_seq_timer.sv
// Interval timer shared by the HOLD and RELEASE phases of the sequencer.
// It counts enabled cycles and flags the cycle in which the count equals the
// terminal value presented by the caller; the caller clears it on that cycle.
module reset_seq_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             tc_o
);

    import reset_seq_pkg::*;

    logic [CNT_W-1:0] cnt_q;

    // Cycle counter: a clear always wins over counting so the next interval
    // starts from zero on the very edge that ended the previous one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Terminal-count flag is only meaningful while the timer is running,
    // so an idle timer sitting at zero never looks like a zero-length interval.
    always_comb begin
        tc_o = 1'b0;
        if (en_i) begin
            tc_o = is_terminal(MAX_CNT_W'(cnt_q), MAX_CNT_W'(term_i));
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset sequencer. After a hard reset (rst_i) or an accepted warm-reset
// request, every domain is held in reset for HOLD_CYCLES, then the domains are
// released one at a time, lowest index first, STAGE_DELAY cycles apart.
// A warm-reset request is only honoured once the sequence has completed.
module reset_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int STAGE_DELAY = 16,
    parameter int CNT_W       = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    reset_sequencer_if.master bus
);

    import reset_seq_pkg::*;

    // Elaboration-time guards: the terminal comparisons are exact, so any
    // interval that does not fit the counter would never terminate.
    if (NUM_STAGES < 1 || NUM_STAGES > MAX_STAGES) begin : g_bad_num_stages
        $fatal(1, "reset_sequencer: NUM_STAGES=%0d outside 1..%0d", NUM_STAGES, MAX_STAGES);
    end
    if (CNT_W < 1 || CNT_W > MAX_CNT_W) begin : g_bad_cnt_w
        $fatal(1, "reset_sequencer: CNT_W=%0d outside 1..%0d", CNT_W, MAX_CNT_W);
    end
    if (HOLD_CYCLES < 1 ||
        longint'(HOLD_CYCLES) > ((longint'(1) << CNT_W) - longint'(1))) begin : g_bad_hold
        $fatal(1, "reset_sequencer: HOLD_CYCLES=%0d does not fit a %0d-bit counter", HOLD_CYCLES, CNT_W);
    end
    if (STAGE_DELAY < 1 ||
        longint'(STAGE_DELAY) > ((longint'(1) << CNT_W) - longint'(1))) begin : g_bad_delay
        $fatal(1, "reset_sequencer: STAGE_DELAY=%0d does not fit a %0d-bit counter", STAGE_DELAY, CNT_W);
    end

    // Terminal values: an interval of N cycles ends when the counter reads N-1.
    localparam logic [CNT_W-1:0] HOLD_TERM  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_TERM = CNT_W'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_STAGES - 1);

    seq_state_t            state_q, state_d;
    logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  done_q, done_d;
    logic                  ack_q, ack_d;
    logic [1:0]            cause_q, cause_d;

    logic                  tmr_clr;
    logic                  tmr_en;
    logic [CNT_W-1:0]      tmr_term;
    logic                  tmr_tc;

    // The timer runs in both timed phases and selects its interval from the
    // current state; DONE leaves it idle at zero.
    assign tmr_en   = (state_q == ST_HOLD) || (state_q == ST_RELEASE);
    assign tmr_term = (state_q == ST_HOLD) ? HOLD_TERM : DELAY_TERM;

    reset_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (tmr_clr),
        .en_i   (tmr_en),
        .term_i (tmr_term),
        .tc_o   (tmr_tc)
    );

    // State and registered outputs; a hard reset forces the whole sequence
    // back to the start with every domain held and the cause marked as hard.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_HOLD;
            stage_rst_q <= '1;
            idx_q       <= '0;
            done_q      <= 1'b0;
            ack_q       <= 1'b0;
            cause_q     <= RST_CAUSE_HARD;
        end else begin
            state_q     <= state_d;
            stage_rst_q <= stage_rst_d;
            idx_q       <= idx_d;
            done_q      <= done_d;
            ack_q       <= ack_d;
            cause_q     <= cause_d;
        end
    end

    // Next-state logic: HOLD waits out the hold interval, RELEASE frees one
    // domain per stage delay, DONE accepts a warm reset and restarts the sequence.
    always_comb begin
        state_d     = state_q;
        stage_rst_d = stage_rst_q;
        idx_d       = idx_q;
        done_d      = done_q;
        ack_d       = 1'b0;
        cause_d     = cause_q;
        tmr_clr     = 1'b0;

        case (state_q)
            ST_HOLD: begin
                if (tmr_tc) begin
                    state_d = ST_RELEASE;
                    idx_d   = '0;
                    tmr_clr = 1'b1;
                end
            end

            ST_RELEASE: begin
                if (tmr_tc) begin
                    tmr_clr = 1'b1;
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            stage_rst_d[i] = 1'b0;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            ST_DONE: begin
                if (bus.soft_rst_req_i) begin
                    state_d     = ST_HOLD;
                    stage_rst_d = '1;
                    idx_d       = '0;
                    done_d      = 1'b0;
                    ack_d       = 1'b1;
                    cause_d     = RST_CAUSE_SOFT;
                    tmr_clr     = 1'b1;
                end
            end

            default: begin
                state_d     = ST_HOLD;
                stage_rst_d = '1;
                idx_d       = '0;
                done_d      = 1'b0;
                tmr_clr     = 1'b1;
            end
        endcase
    end

    // Everything leaves straight from flops except the active-low copy of the
    // domain resets, which is just the inverse of the registered vector.
    assign bus.stage_rst_o    = stage_rst_q;
    assign bus.stage_nrst_o   = ~stage_rst_q;
    assign bus.seq_done_o     = done_q;
    assign bus.soft_rst_ack_o = ack_q;
    assign bus.reset_cause_o  = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for the staged reset sequencer. Three instances share one
// clock and hard reset: the default build, a minimal 1-stage/1-cycle build and
// a 16-stage build. Expected values are hand-computed edge numbers, where edge 1
// is the first rising clock edge after rst_i drops.
module tb_reset_sequencer;

    import reset_seq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   edgeCount = 0;
    int   total     = 0;
    int   bad       = 0;

    // 10 ns clock period
    always #5 clk = ~clk;

    reset_sequencer_if #(.NUM_STAGES(4))  busA ();
    reset_sequencer_if #(.NUM_STAGES(1))  busB ();
    reset_sequencer_if #(.NUM_STAGES(16)) busC ();

    reset_sequencer #(
        .NUM_STAGES(4), .HOLD_CYCLES(8), .STAGE_DELAY(16), .CNT_W(8)
    ) dutA (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (busA.master)
    );

    reset_sequencer #(
        .NUM_STAGES(1), .HOLD_CYCLES(1), .STAGE_DELAY(1), .CNT_W(8)
    ) dutB (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (busB.master)
    );

    reset_sequencer #(
        .NUM_STAGES(16), .HOLD_CYCLES(8), .STAGE_DELAY(16), .CNT_W(8)
    ) dutC (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (busC.master)
    );

    // One comparison: counted always, reported only on a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance a number of rising edges and settle 1 ns past the last one.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            edgeCount++;
        end
        #1;
    endtask

    task automatic stepTo(input int target);
        applyStimulus(target - edgeCount);
    endtask

    // Pulse the hard reset across a rising edge and restart the edge count.
    task automatic hardResetRelease();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("hard_cause", 32'(busA.reset_cause_o), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        edgeCount = 0;
    endtask

    initial begin
        rst = 1'b1;
        busA.soft_rst_req_i = 1'b0;
        busB.soft_rst_req_i = 1'b0;
        busC.soft_rst_req_i = 1'b0;
        #1;

        // Reset values, no clock edge needed.
        checkOutput("rst_stageA", 32'(busA.stage_rst_o),   32'hF);
        checkOutput("rst_nrstA",  32'(busA.stage_nrst_o),  32'h0);
        checkOutput("rst_doneA",  32'(busA.seq_done_o),    32'h0);
        checkOutput("rst_ackA",   32'(busA.soft_rst_ack_o), 32'h0);
        checkOutput("rst_causeA", 32'(busA.reset_cause_o), 32'h1);
        checkOutput("rst_stageB", 32'(busB.stage_rst_o),   32'h1);
        checkOutput("rst_stageC", 32'(busC.stage_rst_o),   32'hFFFF);

        // Power-on sequence.
        @(negedge clk);
        rst = 1'b0;
        edgeCount = 0;

        stepTo(1);
        checkOutput("po1_stageA", 32'(busA.stage_rst_o), 32'hF);
        checkOutput("po1_stageB", 32'(busB.stage_rst_o), 32'h1);
        checkOutput("po1_doneB",  32'(busB.seq_done_o),  32'h0);
        stepTo(2);
        checkOutput("po2_stageB", 32'(busB.stage_rst_o), 32'h0);
        checkOutput("po2_doneB",  32'(busB.seq_done_o),  32'h1);
        stepTo(23);
        checkOutput("po23_stageA", 32'(busA.stage_rst_o), 32'hF);
        stepTo(24);
        checkOutput("po24_stageA", 32'(busA.stage_rst_o), 32'hE);
        checkOutput("po24_stageC", 32'(busC.stage_rst_o), 32'hFFFE);
        stepTo(40);
        checkOutput("po40_stageA", 32'(busA.stage_rst_o),  32'hC);
        checkOutput("po40_nrstA",  32'(busA.stage_nrst_o), 32'h3);
        stepTo(56);
        checkOutput("po56_stageA", 32'(busA.stage_rst_o), 32'h8);
        stepTo(71);
        checkOutput("po71_stageA", 32'(busA.stage_rst_o), 32'h8);
        checkOutput("po71_doneA",  32'(busA.seq_done_o),  32'h0);
        stepTo(72);
        checkOutput("po72_stageA", 32'(busA.stage_rst_o),   32'h0);
        checkOutput("po72_nrstA",  32'(busA.stage_nrst_o),  32'hF);
        checkOutput("po72_doneA",  32'(busA.seq_done_o),    32'h1);
        checkOutput("po72_causeA", 32'(busA.reset_cause_o), 32'h1);
        stepTo(263);
        checkOutput("po263_stageC", 32'(busC.stage_rst_o), 32'h8000);
        checkOutput("po263_doneC",  32'(busC.seq_done_o),  32'h0);
        stepTo(264);
        checkOutput("po264_stageC", 32'(busC.stage_rst_o), 32'h0);
        checkOutput("po264_doneC",  32'(busC.seq_done_o),  32'h1);
        checkOutput("po264_stageA", 32'(busA.stage_rst_o), 32'h0);

        // Warm reset accepted in DONE at edge 265.
        $display("[TB] soft reset from DONE");
        busA.soft_rst_req_i = 1'b1;
        stepTo(265);
        checkOutput("soft_ack",   32'(busA.soft_rst_ack_o), 32'h1);
        checkOutput("soft_stage", 32'(busA.stage_rst_o),    32'hF);
        checkOutput("soft_done",  32'(busA.seq_done_o),     32'h0);
        checkOutput("soft_cause", 32'(busA.reset_cause_o),  32'h2);
        busA.soft_rst_req_i = 1'b0;
        stepTo(266);
        checkOutput("soft_ack_pulse", 32'(busA.soft_rst_ack_o), 32'h0);
        checkOutput("soft_cause_hold", 32'(busA.reset_cause_o), 32'h2);
        stepTo(288);
        checkOutput("soft_e23_stage", 32'(busA.stage_rst_o), 32'hF);
        stepTo(289);
        checkOutput("soft_e24_stage", 32'(busA.stage_rst_o), 32'hE);
        stepTo(337);
        checkOutput("soft_e72_stage", 32'(busA.stage_rst_o), 32'h0);
        checkOutput("soft_e72_done",  32'(busA.seq_done_o),  32'h1);
        checkOutput("soft_causeC",    32'(busC.reset_cause_o), 32'h1);

        // Request raised during RELEASE is held until the sequence completes.
        $display("[TB] early request");
        hardResetRelease();
        stepTo(29);
        busA.soft_rst_req_i = 1'b1;
        stepTo(30);
        checkOutput("early30_ack",   32'(busA.soft_rst_ack_o), 32'h0);
        checkOutput("early30_stage", 32'(busA.stage_rst_o),    32'hE);
        stepTo(71);
        checkOutput("early71_ack",   32'(busA.soft_rst_ack_o), 32'h0);
        stepTo(72);
        checkOutput("early72_ack",   32'(busA.soft_rst_ack_o), 32'h0);
        checkOutput("early72_done",  32'(busA.seq_done_o),     32'h1);
        stepTo(73);
        checkOutput("early73_ack",   32'(busA.soft_rst_ack_o), 32'h1);
        checkOutput("early73_stage", 32'(busA.stage_rst_o),    32'hF);
        checkOutput("early73_cause", 32'(busA.reset_cause_o),  32'h2);
        busA.soft_rst_req_i = 1'b0;
        stepTo(74);
        checkOutput("early74_ack",   32'(busA.soft_rst_ack_o), 32'h0);
        stepTo(96);
        checkOutput("early96_stage", 32'(busA.stage_rst_o), 32'hF);
        stepTo(97);
        checkOutput("early97_stage", 32'(busA.stage_rst_o), 32'hE);

        // Hard reset pulsed between edges in the middle of RELEASE.
        $display("[TB] mid-sequence hard reset");
        hardResetRelease();
        stepTo(45);
        checkOutput("mid45_stage", 32'(busA.stage_rst_o), 32'hC);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_async_stage", 32'(busA.stage_rst_o),   32'hF);
        checkOutput("mid_async_nrst",  32'(busA.stage_nrst_o),  32'h0);
        checkOutput("mid_async_cause", 32'(busA.reset_cause_o), 32'h1);
        checkOutput("mid_async_done",  32'(busA.seq_done_o),    32'h0);
        @(negedge clk);
        rst = 1'b0;
        edgeCount = 0;
        stepTo(23);
        checkOutput("mid_r23_stage", 32'(busA.stage_rst_o), 32'hF);
        stepTo(24);
        checkOutput("mid_r24_stage", 32'(busA.stage_rst_o), 32'hE);

        // Hard reset and warm request together on a DONE edge.
        $display("[TB] collision");
        stepTo(72);
        checkOutput("col_pre_done", 32'(busA.seq_done_o), 32'h1);
        busA.soft_rst_req_i = 1'b1;
        rst = 1'b1;
        applyStimulus(1);
        checkOutput("col_ack",   32'(busA.soft_rst_ack_o), 32'h0);
        checkOutput("col_cause", 32'(busA.reset_cause_o),  32'h1);
        checkOutput("col_stage", 32'(busA.stage_rst_o),    32'hF);
        busA.soft_rst_req_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        edgeCount = 0;
        stepTo(1);
        checkOutput("col_after_ack", 32'(busA.soft_rst_ack_o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
